// File: rtl/wash_job_scheduler.sv
// Job queue and sequencer in front of one washing-machine controller core.
// Define WASH_SCHED_WDOG_EN to build the hung-job watchdog (ABORT state, mc_rst, err_timeout).
module wash_job_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [1:0]               req_prog,
  output logic                     req_ready,
  input  logic                     pause_req,
  input  logic                     mc_done,
  output logic                     mc_start,
  output logic                     mc_dry,
  output logic                     mc_double,
  output logic                     mc_pause,
  output logic                     mc_rst,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [7:0]               jobs_done,
  output logic                     err_reject,
  output logic                     err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);
  localparam logic [1:0]  ProgDouble  = 2'b01;
  localparam logic [1:0]  ProgDry     = 2'b10;
  localparam logic [1:0]  ProgIllegal = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun
`ifdef WASH_SCHED_WDOG_EN
    , StAbort
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    job_prog_q, job_prog_d;
  logic [7:0]    jobs_done_q, jobs_done_d;
  logic          done_d_q;
  logic          err_reject_q, err_reject_d;

  logic push, pop, done_rise, wdog_expire;

`ifdef WASH_SCHED_WDOG_EN
  localparam int unsigned   WdW   = $clog2(WDOG_CYCLES);
  localparam logic [WdW-1:0] WdMax = WdW'(WDOG_CYCLES - 1);

  logic [WdW-1:0] wdog_q, wdog_d;

  // The counter only advances on unpaused RUN cycles; a done rise in the expiry cycle wins.
  always_comb begin
    wdog_d      = wdog_q;
    wdog_expire = 1'b0;
    if (state_q == StLaunch) begin
      wdog_d = '0;
    end else if (state_q == StRun && !pause_req) begin
      if (wdog_q == WdMax) begin
        wdog_expire = !done_rise;
      end else begin
        wdog_d = wdog_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_expire     = 1'b0;
`endif

  assign req_ready = (count_q != CountFull);
  assign push      = req_valid && req_ready && (req_prog != ProgIllegal);
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign done_rise = mc_done && !done_d_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_reject_d = req_valid && (req_prog == ProgIllegal);
    if (push) begin
      mem_d[wr_ptr_q] = req_prog;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    job_prog_d  = job_prog_q;
    jobs_done_d = jobs_done_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          job_prog_d = mem_q[rd_ptr_q];
          state_d    = StLaunch;
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        if (done_rise) begin
          if (jobs_done_q != 8'hFF) begin
            jobs_done_d = jobs_done_q + 8'd1;
          end
          state_d = StIdle;
        end else if (wdog_expire) begin
`ifdef WASH_SCHED_WDOG_EN
          state_d = StAbort;
`endif
        end
      end
`ifdef WASH_SCHED_WDOG_EN
      StAbort: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      job_prog_q   <= '0;
      jobs_done_q  <= '0;
      done_d_q     <= 1'b0;
      err_reject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      job_prog_q   <= job_prog_d;
      jobs_done_q  <= jobs_done_d;
      done_d_q     <= mc_done;
      err_reject_q <= err_reject_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign mc_start   = (state_q == StLaunch) && (job_prog_q != ProgDry);
  assign mc_dry     = (state_q == StLaunch) && (job_prog_q == ProgDry);
  assign mc_double  = (state_q == StLaunch || state_q == StRun) && (job_prog_q == ProgDouble);
  assign mc_pause   = (state_q == StRun) && pause_req;
  assign q_count    = count_q;
  assign jobs_done  = jobs_done_q;
  assign err_reject = err_reject_q;

`ifdef WASH_SCHED_WDOG_EN
  assign mc_rst      = (state_q == StAbort);
  assign err_timeout = (state_q == StAbort);
`else
  assign mc_rst      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wash_job_scheduler.sv
// Directed self-checking bench for wash_job_scheduler (DEPTH=4, WDOG_CYCLES=8).
// Watchdog scenarios follow whether WASH_SCHED_WDOG_EN is defined for the build.
module tb_wash_job_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_prog = 2'b00;
  logic       req_ready;
  logic       pause_req = 1'b0;
  logic       mc_done = 1'b0;
  logic       mc_start, mc_dry, mc_double, mc_pause, mc_rst, busy;
  logic [2:0] q_count;
  logic [7:0] jobs_done;
  logic       err_reject, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wash_job_scheduler #(
    .DEPTH      (4),
    .WDOG_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_prog   (req_prog),
    .req_ready  (req_ready),
    .pause_req  (pause_req),
    .mc_done    (mc_done),
    .mc_start   (mc_start),
    .mc_dry     (mc_dry),
    .mc_double  (mc_double),
    .mc_pause   (mc_pause),
    .mc_rst     (mc_rst),
    .busy       (busy),
    .q_count    (q_count),
    .jobs_done  (jobs_done),
    .err_reject (err_reject),
    .err_timeout(err_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] p);
    req_valid = 1'b1;
    req_prog  = p;
    tick();
    req_valid = 1'b0;
  endtask

  // Complete the running job, then check the next job's launch and entry into RUN.
  task automatic finish_and_next(input string tag, input logic [7:0] exp_jobs,
                                 input logic exp_start, input logic exp_dry,
                                 input logic exp_double);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq({tag, "_jobs"}, jobs_done, exp_jobs);
    check_eq({tag, "_idle"}, busy, 1'b0);
    tick();
    check_eq({tag, "_start"}, mc_start, exp_start);
    check_eq({tag, "_dry"}, mc_dry, exp_dry);
    check_eq({tag, "_double"}, mc_double, exp_double);
    tick();
    check_eq({tag, "_run"}, busy, 1'b1);
    check_eq({tag, "_start_off"}, mc_start | mc_dry, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_q_count", q_count, 3'd0);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_jobs", jobs_done, 8'd0);
    check_eq("rst_mc", {mc_start, mc_dry, mc_double, mc_pause, mc_rst}, 5'b0);
    check_eq("rst_err", {err_reject, err_timeout}, 2'b0);
    rst = 1'b0;

    // Single double-wash job; pause held so the watchdog (if built) stays frozen
    pause_req = 1'b1;
    check_eq("pause_idle", mc_pause, 1'b0);
    push(2'b01);
    check_eq("t1_qc", q_count, 3'd1);
    check_eq("t1_busy_k", busy, 1'b0);
    tick();
    check_eq("t1_start", mc_start, 1'b1);
    check_eq("t1_dry", mc_dry, 1'b0);
    check_eq("t1_double_launch", mc_double, 1'b1);
    check_eq("t1_pause_launch", mc_pause, 1'b0);
    check_eq("t1_qc_pop", q_count, 3'd0);
    tick();
    check_eq("t1_start_off", mc_start, 1'b0);
    check_eq("t1_double_run", mc_double, 1'b1);
    check_eq("t1_pause_run", mc_pause, 1'b1);
    repeat (8) tick();
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq("t1_jobs", jobs_done, 8'd1);
    check_eq("t1_busy_fall", busy, 1'b0);
    check_eq("t1_double_off", mc_double, 1'b0);
    check_eq("t1_pause_off", mc_pause, 1'b0);
    tick();
    check_eq("t1_stay_idle", busy, 1'b0);

    // Fill the queue behind a stalled job
    push(2'b01);
    tick();
    tick();
    check_eq("t2_a_run", busy, 1'b1);
    push(2'b00);
    push(2'b10);
    push(2'b01);
    check_eq("t2_ready3", req_ready, 1'b1);
    push(2'b00);
    check_eq("t2_qc4", q_count, 3'd4);
    check_eq("t2_ready_full", req_ready, 1'b0);
    push(2'b10);
    check_eq("t2_drop5", q_count, 3'd4);
    check_eq("t2_noreject", err_reject, 1'b0);
    push(2'b11);
    check_eq("t2_reject", err_reject, 1'b1);
    check_eq("t2_reject_qc", q_count, 3'd4);
    tick();
    check_eq("t2_reject_pulse", err_reject, 1'b0);

    finish_and_next("t2_j1", 8'd2, 1'b1, 1'b0, 1'b0);
    finish_and_next("t2_j2", 8'd3, 1'b0, 1'b1, 1'b0);
    finish_and_next("t2_j3", 8'd4, 1'b1, 1'b0, 1'b1);
    finish_and_next("t2_j4", 8'd5, 1'b1, 1'b0, 1'b0);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq("t2_jobs6", jobs_done, 8'd6);
    tick();
    check_eq("t2_empty_idle", busy, 1'b0);
    check_eq("t2_empty_qc", q_count, 3'd0);

`ifdef WASH_SCHED_WDOG_EN
    // 20 paused RUN cycles, then abort on the 8th unpaused one
    pause_req = 1'b1;
    push(2'b00);
    tick();
    tick();
    repeat (20) tick();
    pause_req = 1'b0;
    repeat (7) tick();
    check_eq("t3_run28", busy, 1'b1);
    check_eq("t3_no_abort_yet", err_timeout, 1'b0);
    tick();
    check_eq("t3_mc_rst", mc_rst, 1'b1);
    check_eq("t3_err_timeout", err_timeout, 1'b1);
    check_eq("t3_jobs", jobs_done, 8'd6);
    tick();
    check_eq("t3_idle", busy, 1'b0);
    check_eq("t3_rst_pulse", {mc_rst, err_timeout}, 2'b0);

    // Done rise in the expiry cycle wins
    push(2'b00);
    tick();
    tick();
    repeat (7) tick();
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq("t4_jobs", jobs_done, 8'd7);
    check_eq("t4_no_timeout", err_timeout, 1'b0);
    check_eq("t4_idle", busy, 1'b0);
    tick();
    check_eq("t4_no_timeout2", err_timeout, 1'b0);
`else
    // Without the watchdog RUN waits indefinitely
    pause_req = 1'b0;
    push(2'b00);
    tick();
    tick();
    repeat (200) tick();
    check_eq("t4_still_run", busy, 1'b1);
    check_eq("t4_no_timeout", err_timeout, 1'b0);
    check_eq("t4_no_mc_rst", mc_rst, 1'b0);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq("t4_jobs", jobs_done, 8'd7);
    check_eq("t4_idle", busy, 1'b0);
    tick();
`endif

    // Reset mid-RUN with two jobs queued
    pause_req = 1'b1;
    push(2'b01);
    push(2'b00);
    push(2'b10);
    check_eq("t5_qc2", q_count, 3'd2);
    check_eq("t5_run", busy, 1'b1);
    check_eq("t5_double", mc_double, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t5_async_busy", busy, 1'b0);
    tick();
    check_eq("t5_qc0", q_count, 3'd0);
    check_eq("t5_busy0", busy, 1'b0);
    check_eq("t5_jobs0", jobs_done, 8'd0);
    check_eq("t5_mc0", {mc_start, mc_dry, mc_double, mc_pause, mc_rst}, 5'b0);
    check_eq("t5_ready", req_ready, 1'b1);
    rst = 1'b0;
    pause_req = 1'b0;
    push(2'b10);
    tick();
    check_eq("t5_dry_launch", mc_dry, 1'b1);
    check_eq("t5_post_qc", q_count, 3'd0);
    tick();
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check_eq("t5_jobs1", jobs_done, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
